step_segment_exec: RTL and testbench
====================================

Name: step_segment_exec

Overview:
- Downstream consumer of the record FIFO.
- Pops one motion record at a time, unpacks it, and generates step/dir pulse trains on AXES outputs for the record's step count at the record's period.
- Sits between the record FIFO (SPI-fed) and the motor driver pins.
- One clock domain; synchronous active-high reset.

Parameters:
- AXES, 4: number of step/dir output pairs (1..8).
- RECORD_BITS, 64: width of fifo_data; must equal the FIFO's record width (RECORD_SIZE*INPUT_SIZE_BYTES*8).
- PULSE_WIDTH, 8: clk cycles the step output stays high per step (>=1).
- DIR_SETUP, 4: clk cycles dir is held stable before a segment's first step edge (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- fifo_empty  input  1  record FIFO has no complete record.
- fifo_data  input  RECORD_BITS  record FIFO data_out; valid the cycle after a read is sampled.
- fifo_read_en  output  1  one-cycle pop request to the record FIFO.
- step  output  AXES  step pulses, active high.
- dir  output  AXES  direction levels.
- busy  output  1  high from pop until the last step's low phase ends.
- seg_done  output  1  one-cycle pulse when a segment completes or is skipped.

Behaviour:
- Record layout (little-endian bit fields of fifo_data):
  - [15:0] count: steps, unsigned.
  - [31:16] period: cycles between step rising edges, unsigned.
  - [39:32] dir: bit i drives dir[i].
  - [47:40] enable: bit i lets axis i step.
  - Bits above 47 ignored; bits of dir/enable >= AXES ignored.
- Reset (clk edge with reset=1): state IDLE, fifo_read_en=0, step=0, dir=0, busy=0, seg_done=0, all counters 0. Reset mid-segment aborts immediately; the popped record is discarded; step low on the next cycle.
- States: IDLE, READ, WAIT, SETUP, STEP_HI, STEP_LO.
- IDLE: if fifo_empty=0, go to READ. All outputs registered.
- READ: fifo_read_en=1 for exactly this cycle; busy=1; go to WAIT.
- WAIT: fifo_data valid; latch count, period_eff, dir, enable at the end of this cycle.
  - If count==0: pulse seg_done next cycle and go to IDLE; dir unchanged.
  - Else: go to SETUP.
- period_eff = max(period, PULSE_WIDTH+1), computed in 17 bits, no wrap.
- SETUP: dir driven from the latched value; hold DIR_SETUP cycles; then go to STEP_HI.
- STEP_HI: step = enable mask (disabled axes stay 0) for PULSE_WIDTH cycles; then go to STEP_LO.
- STEP_LO: step=0 for period_eff-PULSE_WIDTH cycles.
  - At the end, decrement the remaining count.
  - If remaining count hits 0: seg_done=1 for one cycle, busy=0, go to IDLE.
  - Else go to STEP_HI.
- Latency: fifo_empty seen low in IDLE cycle t → fifo_read_en at t+1 → record latched end of t+2 → dir at t+3 → first step rising at t+3+DIR_SETUP.
- Back-to-back segments: from the STEP_LO→IDLE transition, the next step rise is at least 3+DIR_SETUP cycles after the previous segment's last low phase. dir changes only on segment boundaries.
- fifo_read_en is never asserted outside READ; never asserted while fifo_empty was 1 in the preceding IDLE cycle.
- Step counting: count=65535 produces exactly 65535 pulses; the 16-bit counter never wraps.
- All enable bits 0 with count>0: timing runs normally, step stays 0, seg_done still pulses.

Optional Feature:
- Macro STEP_SEG_ABORT_EN.
- Defined: adds port abort (input, 1).
  - abort=1 in any state forces step=0 and busy=0 on the next cycle, discards the current record, and enters IDLE.
  - IDLE does not pop while abort=1.
  - seg_done is not pulsed for an aborted segment.
  - dir holds its last value.
- Undefined: no abort port; segments always run to completion.

Test Plan:
- Reset then one record count=3, period=20, dir=4'b0101, enable=4'b0011 → dir=0101 at t+3; step[1:0]=11 high 8 cycles at rises t+7, t+27, t+47; step[3:2]=0; seg_done one cycle after the last 12-cycle low phase.
- Record period=2, count=2 → period clamped to 9: rises 9 cycles apart, high 8 / low 1.
- Record count=0 → exactly one fifo_read_en, seg_done at t+3, no step activity, dir unchanged.
- Two records queued (count=1 each, dir 0001 then 0000) → two pops, dir changes only after the first seg_done, second step rise ≥ 3+DIR_SETUP cycles after the first segment ends.
- Assert reset during the second STEP_HI of a count=5 record → step=0 and busy=0 the next cycle, then IDLE with no pop while reset=1.
- (STEP_SEG_ABORT_EN) abort=1 for 1 cycle mid-segment with fifo non-empty → step=0 next cycle, no seg_done, next record popped once abort=0.

Source files
------------

// File: rtl/step_segment_exec.sv
// step_segment_exec: pops motion records and drives step/dir pulse trains; define STEP_SEG_ABORT_EN to add an abort input.
module step_segment_exec #(
  parameter int AXES        = 4,
  parameter int RECORD_BITS = 64,
  parameter int PULSE_WIDTH = 8,
  parameter int DIR_SETUP   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef STEP_SEG_ABORT_EN
  input  logic                   abort,
`endif
  input  logic                   fifo_empty,
  input  logic [RECORD_BITS-1:0] fifo_data,
  output logic                   fifo_read_en,
  output logic [AXES-1:0]        step,
  output logic [AXES-1:0]        dir,
  output logic                   busy,
  output logic                   seg_done
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, SETUP, STEP_HI, STEP_LO} state_t;
  state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [16:0] per, per_n, tmr, tmr_n, rec_per;
  logic [AXES-1:0] en, en_n, dir_n, step_n;
  logic rd_n, busy_n, done_n, rec_zero, tick, last, kill;
  logic unused_data;
`ifdef STEP_SEG_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif
  assign unused_data = ^fifo_data;
  assign rec_zero = fifo_data[15:0] == 16'd0;
  assign rec_per = {1'b0, fifo_data[31:16]} < 17'(PULSE_WIDTH + 1) ? 17'(PULSE_WIDTH + 1) : {1'b0, fifo_data[31:16]};
  assign tick = tmr == 17'd0;
  assign last = cnt == 16'd1;
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = fifo_empty ? IDLE : READ;
      READ:    state_n = WAIT;
      WAIT:    state_n = rec_zero ? IDLE : SETUP;
      SETUP:   state_n = tick ? STEP_HI : SETUP;
      STEP_HI: state_n = tick ? STEP_LO : STEP_HI;
      STEP_LO: state_n = !tick ? STEP_LO : last ? IDLE : STEP_HI;
      default: state_n = IDLE;
    endcase
    if (kill) state_n = IDLE;
  end
  // Outputs are next-state decoded and registered, so they change together with the state.
  always_comb begin
    rd_n   = state_n == READ;
    busy_n = state_n != IDLE;
    step_n = state_n == STEP_HI ? en : '0;
    done_n = !kill && ((state == WAIT && rec_zero) || (state == STEP_LO && tick && last));
    dir_n  = (!kill && state == WAIT && !rec_zero) ? fifo_data[32 +: AXES] : dir;
    en_n   = state == WAIT ? fifo_data[40 +: AXES] : en;
    per_n  = state == WAIT ? rec_per : per;
    cnt_n  = state == WAIT ? fifo_data[15:0] : (state == STEP_LO && tick) ? cnt - 16'd1 : cnt;
    tmr_n  = state_n == state ? (tick ? tmr : tmr - 17'd1) :
             state_n == SETUP ? 17'(DIR_SETUP - 1) :
             state_n == STEP_HI ? 17'(PULSE_WIDTH - 1) :
             state_n == STEP_LO ? per - 17'(PULSE_WIDTH + 1) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_read_en <= 1'b0;
      busy         <= 1'b0;
      seg_done     <= 1'b0;
      step         <= '0;
      dir          <= '0;
      en           <= '0;
      per          <= '0;
      cnt          <= '0;
      tmr          <= '0;
    end else begin
      fifo_read_en <= rd_n;
      busy         <= busy_n;
      seg_done     <= done_n;
      step         <= step_n;
      dir          <= dir_n;
      en           <= en_n;
      per          <= per_n;
      cnt          <= cnt_n;
      tmr          <= tmr_n;
    end
  end
endmodule

// File: tb/tb_step_segment_exec.sv
// tb_step_segment_exec: directed scenarios against step_segment_exec with a small record FIFO model.
module tb_step_segment_exec;
  logic clk = 1'b0, reset = 1'b1, abort = 1'b0;
  logic fifo_empty, fifo_read_en, busy, seg_done;
  logic [63:0] fifo_data = '0;
  logic [3:0] step, dir;
  logic [63:0] mem [0:7];
  int wp = 0, rp = 0, n_checks = 0, n_fail = 0;
  int re_n, rise_n, hi_n, sd_n, bz_fall;
  int re_k [0:3];
  int rise_k [0:7];
  int sd_k [0:3];
  logic [3:0] st_or;
  logic [3:0] dir_log [0:99];
  logic bz_log [0:99];

  step_segment_exec dut (
    .clk(clk), .reset(reset),
`ifdef STEP_SEG_ABORT_EN
    .abort(abort),
`endif
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read_en(fifo_read_en),
    .step(step), .dir(dir), .busy(busy), .seg_done(seg_done)
  );

  always #5 clk = ~clk;
  assign fifo_empty = (wp == rp);
  always @(posedge clk) if (fifo_read_en && wp != rp) begin
    fifo_data <= mem[rp % 8];
    rp <= rp + 1;
  end

  function automatic logic [63:0] rec(input logic [15:0] c, input logic [15:0] p, input logic [3:0] d, input logic [3:0] e);
    return {16'hDEAD, 4'hA, e, 4'h5, d, p, c};
  endfunction

  task automatic push(input logic [63:0] r);
    mem[wp % 8] = r;
    wp++;
  endtask

  task automatic observe(input int n);
    logic [3:0] prev;
    re_n = 0; rise_n = 0; hi_n = 0; sd_n = 0; bz_fall = 0; st_or = '0; prev = step;
    for (int i = 0; i < 4; i++) begin re_k[i] = -1; sd_k[i] = -1; end
    for (int i = 0; i < 8; i++) rise_k[i] = -1;
    bz_log[0] = busy; dir_log[0] = dir;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (fifo_read_en) begin if (re_n < 4) re_k[re_n] = k; re_n++; end
      if (step != 0 && prev == 0) begin if (rise_n < 8) rise_k[rise_n] = k; rise_n++; end
      if (step != 0) hi_n++;
      st_or |= step;
      prev = step;
      if (seg_done) begin if (sd_n < 4) sd_k[sd_n] = k; sd_n++; end
      if (!busy && bz_log[k-1] && bz_fall == 0) bz_fall = k;
      dir_log[k] = dir; bz_log[k] = busy;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({fifo_read_en, step, dir, busy, seg_done} !== 11'b0) begin n_fail++; $display("FAIL reset_outputs: got %b want 0", {fifo_read_en, step, dir, busy, seg_done}); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    push(rec(16'd3, 16'd20, 4'b0101, 4'b0011));
    observe(70);
    n_checks++; if (re_n !== 1) begin n_fail++; $display("FAIL basic_pops: got %0d want 1", re_n); end
    n_checks++; if (re_k[0] !== 1) begin n_fail++; $display("FAIL basic_pop_time: got %0d want 1", re_k[0]); end
    n_checks++; if (dir_log[2] !== 4'b0000) begin n_fail++; $display("FAIL basic_dir_early: got %b want 0000", dir_log[2]); end
    n_checks++; if (dir_log[3] !== 4'b0101) begin n_fail++; $display("FAIL basic_dir: got %b want 0101", dir_log[3]); end
    n_checks++; if (rise_n !== 3) begin n_fail++; $display("FAIL basic_rises: got %0d want 3", rise_n); end
    n_checks++; if (rise_k[0] !== 7) begin n_fail++; $display("FAIL basic_rise0: got %0d want 7", rise_k[0]); end
    n_checks++; if (rise_k[1] !== 27) begin n_fail++; $display("FAIL basic_rise1: got %0d want 27", rise_k[1]); end
    n_checks++; if (rise_k[2] !== 47) begin n_fail++; $display("FAIL basic_rise2: got %0d want 47", rise_k[2]); end
    n_checks++; if (hi_n !== 24) begin n_fail++; $display("FAIL basic_high_cycles: got %0d want 24", hi_n); end
    n_checks++; if (st_or !== 4'b0011) begin n_fail++; $display("FAIL basic_step_mask: got %b want 0011", st_or); end
    n_checks++; if (sd_n !== 1 || sd_k[0] !== 67) begin n_fail++; $display("FAIL basic_seg_done: got %0d pulses at %0d want 1 at 67", sd_n, sd_k[0]); end
    n_checks++; if (bz_log[1] !== 1'b1 || bz_fall !== 67) begin n_fail++; $display("FAIL basic_busy: got rise %b fall %0d want 1 / 67", bz_log[1], bz_fall); end
  endtask

  task automatic test_period_clamp();
    push(rec(16'd2, 16'd2, 4'b0010, 4'b0001));
    observe(30);
    n_checks++; if (rise_n !== 2 || rise_k[0] !== 7 || rise_k[1] !== 16) begin n_fail++; $display("FAIL clamp_rises: got %0d at %0d,%0d want 2 at 7,16", rise_n, rise_k[0], rise_k[1]); end
    n_checks++; if (hi_n !== 16) begin n_fail++; $display("FAIL clamp_high_cycles: got %0d want 16", hi_n); end
    n_checks++; if (sd_k[0] !== 25) begin n_fail++; $display("FAIL clamp_seg_done: got %0d want 25", sd_k[0]); end
    n_checks++; if (dir_log[3] !== 4'b0010) begin n_fail++; $display("FAIL clamp_dir: got %b want 0010", dir_log[3]); end
  endtask

  task automatic test_zero_count();
    push(rec(16'd0, 16'd20, 4'b1111, 4'b1111));
    observe(8);
    n_checks++; if (re_n !== 1) begin n_fail++; $display("FAIL zero_pops: got %0d want 1", re_n); end
    n_checks++; if (sd_n !== 1 || sd_k[0] !== 3) begin n_fail++; $display("FAIL zero_seg_done: got %0d at %0d want 1 at 3", sd_n, sd_k[0]); end
    n_checks++; if (hi_n !== 0) begin n_fail++; $display("FAIL zero_steps: got %0d want 0", hi_n); end
    n_checks++; if (dir_log[8] !== 4'b0010) begin n_fail++; $display("FAIL zero_dir_hold: got %b want 0010", dir_log[8]); end
    n_checks++; if (bz_fall !== 3) begin n_fail++; $display("FAIL zero_busy_fall: got %0d want 3", bz_fall); end
  endtask

  task automatic test_back_to_back();
    push(rec(16'd1, 16'd20, 4'b0001, 4'b0001));
    push(rec(16'd1, 16'd20, 4'b0000, 4'b0001));
    observe(60);
    n_checks++; if (re_n !== 2 || re_k[1] !== 28) begin n_fail++; $display("FAIL b2b_pops: got %0d second at %0d want 2 / 28", re_n, re_k[1]); end
    n_checks++; if (sd_n !== 2 || sd_k[0] !== 27 || sd_k[1] !== 54) begin n_fail++; $display("FAIL b2b_seg_done: got %0d at %0d,%0d want 2 at 27,54", sd_n, sd_k[0], sd_k[1]); end
    n_checks++; if (rise_k[0] !== 7 || rise_k[1] !== 34) begin n_fail++; $display("FAIL b2b_rises: got %0d,%0d want 7,34", rise_k[0], rise_k[1]); end
    n_checks++; if (dir_log[29] !== 4'b0001 || dir_log[30] !== 4'b0000) begin n_fail++; $display("FAIL b2b_dir: got %b,%b want 0001,0000", dir_log[29], dir_log[30]); end
  endtask

  task automatic test_reset_mid();
    int pops;
    push(rec(16'd5, 16'd20, 4'b1010, 4'b1111));
    observe(28);
    n_checks++; if (rise_k[1] !== 27 || step !== 4'b1111) begin n_fail++; $display("FAIL rst_mid_pre: got rise %0d step %b want 27 / 1111", rise_k[1], step); end
    reset = 1'b1;
    push(rec(16'd0, 16'd20, 4'b0011, 4'b1111));
    @(negedge clk);
    n_checks++; if ({step, busy, dir} !== 9'b0) begin n_fail++; $display("FAIL rst_mid_outputs: got %b want 0", {step, busy, dir}); end
    pops = 0;
    repeat (3) begin @(negedge clk); if (fifo_read_en) pops++; end
    n_checks++; if (pops !== 0) begin n_fail++; $display("FAIL rst_mid_no_pop: got %0d want 0", pops); end
    reset = 1'b0;
    observe(6);
    n_checks++; if (re_k[0] !== 1 || sd_k[0] !== 3) begin n_fail++; $display("FAIL rst_mid_resume: got pop %0d done %0d want 1 / 3", re_k[0], sd_k[0]); end
    n_checks++; if (dir_log[6] !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_dir: got %b want 0000", dir_log[6]); end
  endtask

`ifdef STEP_SEG_ABORT_EN
  task automatic test_abort();
    push(rec(16'd3, 16'd20, 4'b0101, 4'b0011));
    push(rec(16'd0, 16'd20, 4'b1111, 4'b1111));
    observe(10);
    n_checks++; if (rise_k[0] !== 7 || step !== 4'b0011) begin n_fail++; $display("FAIL abort_pre: got rise %0d step %b want 7 / 0011", rise_k[0], step); end
    abort = 1'b1;
    @(negedge clk);
    n_checks++; if ({step, busy, seg_done, fifo_read_en} !== 7'b0) begin n_fail++; $display("FAIL abort_outputs: got %b want 0", {step, busy, seg_done, fifo_read_en}); end
    abort = 1'b0;
    observe(6);
    n_checks++; if (re_n !== 1 || re_k[0] !== 1) begin n_fail++; $display("FAIL abort_next_pop: got %0d at %0d want 1 at 1", re_n, re_k[0]); end
    n_checks++; if (sd_n !== 1 || sd_k[0] !== 3 || hi_n !== 0) begin n_fail++; $display("FAIL abort_next_seg: got done %0d at %0d steps %0d want 1 at 3 / 0", sd_n, sd_k[0], hi_n); end
    n_checks++; if (dir_log[6] !== 4'b0101) begin n_fail++; $display("FAIL abort_dir_hold: got %b want 0101", dir_log[6]); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_period_clamp();
    test_zero_count();
    test_back_to_back();
    test_reset_mid();
`ifdef STEP_SEG_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
